// File: rtl/rcm_pkg.sv
// ----------------------------------------------------------------------------
// rcm_pkg
//   Shared definitions for the ring counter monitor:
//     - FSM state encodings (SEARCH / ACQUIRE / LOCKED)
//     - idx_width(): width of a binary index into an n-entry vector (min 1)
//     - rotl1():     rotate-left-by-one of the low n bits of a vector
// ----------------------------------------------------------------------------
package rcm_pkg;

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  // Widest ring the rotate helper can handle.
  localparam int ROT_MAX = 64;

  // Never returns 0, so a 2-entry ring still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Rotates bits [n-1:0] left by one position: bit n-1 wraps to bit 0.
  // Bits at or above n are returned as 0.
  function automatic logic [ROT_MAX-1:0] rotl1(input logic [ROT_MAX-1:0] v,
                                               input int                 n);
    logic [ROT_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < ROT_MAX; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// ----------------------------------------------------------------------------
// onehot_encoder
//   Purely combinational one-hot to binary encoder.
//   Ports:
//     i_ring   [N-1:0]      vector under test
//     o_valid               exactly one bit of i_ring is set
//     o_idx    [IDX_W-1:0]  position of the set bit (meaningful only if o_valid)
// ----------------------------------------------------------------------------
module onehot_encoder
  import rcm_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_ring,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    logic seen;
    logic multi;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    seen  = 1'b0;
    multi = 1'b0;
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_ring[i]) begin
        if (seen) multi = 1'b1;
        seen  = 1'b1;
        o_idx = o_idx | IDX_W'(i);
      end
    end
    o_valid = seen && !multi;
  end

endmodule

// File: rtl/ring_counter_monitor.sv
// ----------------------------------------------------------------------------
// ring_counter_monitor
//   Health monitor for an N-bit one-hot ring counter. Each strobed sample is
//   encoded to a binary index and compared against the previous one-hot
//   sample rotated left by one. LOCK_CNT consecutive legal advances declare
//   lock; while locked, every illegal sample raises an error pulse and bumps
//   a saturating error counter.
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous active-low reset
//     en_i         sample strobe
//     ring_i       [N-1:0] ring vector
//     clr_i        synchronous clear of err_cnt_o (a coincident error wins as 1)
//     idx_o        [IDX_W-1:0] index of last one-hot sample
//     onehot_ok_o  last sample was exactly one-hot
//     locked_o     FSM is in LOCKED
//     wrap_o       pulse: legal N-1 -> 0 advance while locked
//     err_pulse_o  pulse: sequence error while locked
//     err_cnt_o    [ERR_W-1:0] saturating error count
// ----------------------------------------------------------------------------
module ring_counter_monitor
  import rcm_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int IDX_W    = idx_width(N),
  localparam int GOOD_W   = idx_width(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [N-1:0]     ring_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             onehot_ok_o,
  output logic             locked_o,
  output logic             wrap_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic [1:0]        r_state;
  logic [N-1:0]      r_prev;
  logic [IDX_W-1:0]  r_idx;
  logic              r_ok;
  logic [GOOD_W-1:0] r_good;
  logic              r_wrap;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_valid;
  logic [IDX_W-1:0]  w_pos;
  logic [N-1:0]      w_expect;
  logic              w_legal;
  logic [1:0]        w_state_nxt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic              w_err;
  logic              w_wrap;
  logic              w_sat;

  onehot_encoder #(.N(N)) u_enc (
    .i_ring  (ring_i),
    .o_valid (w_valid),
    .o_idx   (w_pos)
  );

  // The only legal successor of the previous one-hot sample. With prev = 0
  // (after reset) this is 0, which a one-hot sample can never match.
  assign w_expect = N'(rotl1(ROT_MAX'(r_prev), N));
  assign w_legal  = w_valid && (ring_i == w_expect);
  assign w_sat    = &r_err_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    if (en_i) begin
      case (r_state)
        SEARCH: begin
          if (w_valid) begin
            w_state_nxt = ACQUIRE;
            w_good_nxt  = '0;
          end
        end
        ACQUIRE: begin
          if (!w_valid) begin
            w_state_nxt = SEARCH;
          end else if (w_legal) begin
            // This advance is the LOCK_CNT-th one in a row.
            if (r_good == GOOD_W'(LOCK_CNT - 1)) w_state_nxt = LOCKED;
            w_good_nxt = r_good + GOOD_W'(1);
          end else begin
            w_good_nxt = '0;
          end
        end
        LOCKED: begin
          if (w_legal) begin
            // prev is one-hot here, so its top bit marks index N-1.
            w_wrap = r_prev[N-1];
          end else begin
            w_err       = 1'b1;
            w_good_nxt  = '0;
            w_state_nxt = w_valid ? ACQUIRE : SEARCH;
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEARCH;
      r_prev  <= '0;
      r_idx   <= '0;
      r_ok    <= 1'b0;
      r_good  <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_wrap  <= w_wrap;
      r_err   <= w_err;
      if (en_i) begin
        r_ok <= w_valid;
        // A malformed sample must not disturb the reference position.
        if (w_valid) begin
          r_prev <= ring_i;
          r_idx  <= w_pos;
        end
      end
    end
  end

  // Clear takes priority over the old count, but an error on the same edge
  // is still recorded as the first one after the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (clr_i) begin
      r_err_cnt <= w_err ? ERR_W'(1) : '0;
    end else if (w_err && !w_sat) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign idx_o       = r_idx;
  assign onehot_ok_o = r_ok;
  assign locked_o    = (r_state == LOCKED);
  assign wrap_o      = r_wrap;
  assign err_pulse_o = r_err;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// ----------------------------------------------------------------------------
// tb_ring_counter_monitor
//   Directed scenarios plus a randomized run for ring_counter_monitor
//   (N=4, LOCK_CNT=3, ERR_W=2). A position-based reference model tracks the
//   expected outputs: it reasons about hot positions and a streak count
//   rather than the design's registers.
// ----------------------------------------------------------------------------
module tb_ring_counter_monitor;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 2;
  localparam int IDX_W    = 2;
  localparam int W_OUT    = IDX_W + 4 + ERR_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             en_i;
  logic [N-1:0]     ring_i;
  logic             clr_i;
  logic [IDX_W-1:0] idx_o;
  logic             onehot_ok_o;
  logic             locked_o;
  logic             wrap_o;
  logic             err_pulse_o;
  logic [ERR_W-1:0] err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: m_prev_pos = -1 means no one-hot sample seen yet;
  // m_good = -1 means searching, otherwise the current streak length.
  int m_prev_pos, m_good, m_idx, m_errs;
  bit m_locked, m_ok, m_wrap, m_err;

  always #5 clk = ~clk;

  ring_counter_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en_i        (en_i),
    .ring_i      (ring_i),
    .clr_i       (clr_i),
    .idx_o       (idx_o),
    .onehot_ok_o (onehot_ok_o),
    .locked_o    (locked_o),
    .wrap_o      (wrap_o),
    .err_pulse_o (err_pulse_o),
    .err_cnt_o   (err_cnt_o)
  );

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic int hot_pos(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [W_OUT-1:0] observed();
    return {idx_o, onehot_ok_o, locked_o, wrap_o, err_pulse_o, err_cnt_o};
  endfunction

  function automatic logic [W_OUT-1:0] expected();
    return {IDX_W'(m_idx), m_ok, m_locked, m_wrap, m_err, ERR_W'(m_errs)};
  endfunction

  task automatic model_reset();
    m_prev_pos = -1; m_good = -1; m_idx = 0; m_errs = 0;
    m_locked = 0; m_ok = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step(input bit en, input logic [N-1:0] ring, input bit clr);
    int pos;
    bit legal, err_now;
    pos     = hot_pos(ring);
    err_now = 0;
    m_wrap  = 0;
    if (en) begin
      legal = (pos >= 0) && (m_prev_pos >= 0) && (pos == (m_prev_pos + 1) % N);
      if (m_locked) begin
        if (legal) m_wrap = (m_prev_pos == N - 1);
        else begin
          err_now  = 1;
          m_locked = 0;
          m_good   = (pos >= 0) ? 0 : -1;
        end
      end else if (m_good < 0) begin
        if (pos >= 0) m_good = 0;
      end else if (pos < 0) begin
        m_good = -1;
      end else if (legal) begin
        m_good++;
        if (m_good >= LOCK_CNT) m_locked = 1;
      end else begin
        m_good = 0;
      end
      if (pos >= 0) begin
        m_ok = 1; m_idx = pos; m_prev_pos = pos;
      end else begin
        m_ok = 0;
      end
    end
    m_err = err_now;
    if (clr) m_errs = err_now ? 1 : 0;
    else if (err_now && m_errs < (1 << ERR_W) - 1) m_errs++;
  endtask

  // Applies one cycle of stimulus; outputs are stable 1 time unit after the edge.
  task automatic drive(input bit en, input logic [N-1:0] ring, input bit clr);
    @(negedge clk);
    en_i = en; ring_i = ring; clr_i = clr;
    @(posedge clk);
    #1;
    model_step(en, ring, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en_i = 0; clr_i = 0; ring_i = '0; reset = 0;
    #3;
    reset = 1;
    model_reset();
  endtask

  task automatic lock_from_reset();
    for (int p = 0; p < N; p++) drive(1, onehot(p), 0);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (observed() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", observed(), {W_OUT{1'b0}});
    end
    @(negedge clk);
    #2 reset = 1;
    model_reset();
    drive(1, 4'b0001, 0);
    n_checks++;
    if (onehot_ok_o !== 1'b1 || idx_o !== 2'd0 || locked_o !== 1'b0) begin
      n_fail++; $display("FAIL first_sample: ok=%b idx=%0d locked=%b want ok=1 idx=0 locked=0",
                         onehot_ok_o, idx_o, locked_o);
    end
  endtask

  task automatic test_lock_wrap();
    do_reset();
    for (int p = 0; p < N; p++) begin
      drive(1, onehot(p), 0);
      n_checks++;
      if (idx_o !== IDX_W'(p) || locked_o !== (p == N - 1) || wrap_o !== 1'b0) begin
        n_fail++; $display("FAIL lock_seq_%0d: idx=%0d locked=%b wrap=%b want idx=%0d locked=%b wrap=0",
                           p, idx_o, locked_o, wrap_o, p, (p == N - 1));
      end
    end
    drive(1, 4'b0001, 0);
    n_checks++;
    if (wrap_o !== 1'b1 || idx_o !== 2'd0 || locked_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pulse: wrap=%b idx=%0d locked=%b want 1 0 1", wrap_o, idx_o, locked_o);
    end
    drive(1, 4'b0010, 0);
    n_checks++;
    if (wrap_o !== 1'b0 || locked_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap_single_cycle: wrap=%b locked=%b want 0 1", wrap_o, locked_o);
    end
  endtask

  task automatic test_seq_error();
    do_reset();
    lock_from_reset();
    drive(1, 4'b0001, 0);
    drive(1, 4'b0010, 0);
    drive(1, 4'b1000, 0);
    n_checks++;
    if (err_pulse_o !== 1'b1 || err_cnt_o !== 2'd1 || locked_o !== 1'b0 || idx_o !== 2'd3) begin
      n_fail++; $display("FAIL skip_error: err=%b cnt=%0d locked=%b idx=%0d want 1 1 0 3",
                         err_pulse_o, err_cnt_o, locked_o, idx_o);
    end
    drive(1, 4'b0001, 0);
    n_checks++;
    if (err_pulse_o !== 1'b0 || locked_o !== 1'b0) begin
      n_fail++; $display("FAIL err_single_cycle: err=%b locked=%b want 0 0", err_pulse_o, locked_o);
    end
    drive(1, 4'b0010, 0);
    drive(1, 4'b0100, 0);
    n_checks++;
    if (locked_o !== 1'b1 || err_cnt_o !== 2'd1) begin
      n_fail++; $display("FAIL relock: locked=%b cnt=%0d want 1 1", locked_o, err_cnt_o);
    end
  endtask

  task automatic test_nonhot_error();
    drive(1, 4'b0011, 0);
    n_checks++;
    if (onehot_ok_o !== 1'b0 || idx_o !== 2'd2 || err_pulse_o !== 1'b1 ||
        err_cnt_o !== 2'd2 || locked_o !== 1'b0) begin
      n_fail++; $display("FAIL multi_hot_error: ok=%b idx=%0d err=%b cnt=%0d locked=%b want 0 2 1 2 0",
                         onehot_ok_o, idx_o, err_pulse_o, err_cnt_o, locked_o);
    end
    drive(1, 4'b0000, 0);
    n_checks++;
    if (err_pulse_o !== 1'b0 || err_cnt_o !== 2'd2 || onehot_ok_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_in_search: err=%b cnt=%0d ok=%b want 0 2 0",
                         err_pulse_o, err_cnt_o, onehot_ok_o);
    end
    drive(1, 4'b1000, 0);
    n_checks++;
    if (onehot_ok_o !== 1'b1 || idx_o !== 2'd3 || locked_o !== 1'b0 || err_pulse_o !== 1'b0) begin
      n_fail++; $display("FAIL search_to_acquire: ok=%b idx=%0d locked=%b err=%b want 1 3 0 0",
                         onehot_ok_o, idx_o, locked_o, err_pulse_o);
    end
  endtask

  task automatic test_saturate_clear();
    int p;
    do_reset();
    lock_from_reset();
    p = N - 1;
    for (int k = 0; k < 5; k++) begin
      drive(1, onehot(p), 0);
      n_checks++;
      if (err_pulse_o !== 1'b1 || err_cnt_o !== ERR_W'((k + 1 > 3) ? 3 : k + 1)) begin
        n_fail++; $display("FAIL saturate_%0d: err=%b cnt=%0d want 1 %0d",
                           k, err_pulse_o, err_cnt_o, (k + 1 > 3) ? 3 : k + 1);
      end
      for (int j = 0; j < LOCK_CNT; j++) begin
        p = (p + 1) % N;
        drive(1, onehot(p), 0);
      end
    end
    drive(1, onehot(p), 1);
    n_checks++;
    if (err_pulse_o !== 1'b1 || err_cnt_o !== 2'd1) begin
      n_fail++; $display("FAIL clear_with_error: err=%b cnt=%0d want 1 1", err_pulse_o, err_cnt_o);
    end
    for (int j = 0; j < LOCK_CNT; j++) begin
      p = (p + 1) % N;
      drive(1, onehot(p), 0);
    end
    drive(0, 4'b1111, 1);
    n_checks++;
    if (err_cnt_o !== 2'd0 || locked_o !== 1'b1 || err_pulse_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_alone: cnt=%0d locked=%b err=%b want 0 1 0",
                         err_cnt_o, locked_o, err_pulse_o);
    end
  endtask

  task automatic test_hold();
    logic [N-1:0] junk;
    do_reset();
    lock_from_reset();
    for (int k = 0; k < 5; k++) begin
      junk = N'($urandom);
      drive(0, junk, 0);
      n_checks++;
      if (observed() !== {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
        n_fail++; $display("FAIL idle_hold_%0d: got %b want %b", k, observed(),
                           {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
      end
    end
    drive(1, 4'b0001, 0);
    n_checks++;
    if (locked_o !== 1'b1 || err_pulse_o !== 1'b0 || idx_o !== 2'd0 || err_cnt_o !== 2'd0) begin
      n_fail++; $display("FAIL idle_resume: locked=%b err=%b idx=%0d cnt=%0d want 1 0 0 0",
                         locked_o, err_pulse_o, idx_o, err_cnt_o);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    lock_from_reset();
    drive(1, 4'b0001, 0);
    drive(1, 4'b0011, 0);
    @(negedge clk);
    en_i = 0;
    #2 reset = 0;
    #1;
    n_checks++;
    if (observed() !== '0) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", observed(), {W_OUT{1'b0}});
    end
    @(negedge clk);
    #2 reset = 1;
    model_reset();
    drive(1, 4'b0010, 0);
    drive(1, 4'b0100, 0);
    drive(1, 4'b1000, 0);
    n_checks++;
    if (locked_o !== 1'b0 || idx_o !== 2'd3) begin
      n_fail++; $display("FAIL reacquire_early: locked=%b idx=%0d want 0 3", locked_o, idx_o);
    end
    drive(1, 4'b0001, 0);
    n_checks++;
    if (locked_o !== 1'b1 || wrap_o !== 1'b0) begin
      n_fail++; $display("FAIL reacquire_lock: locked=%b wrap=%b want 1 0", locked_o, wrap_o);
    end
  endtask

  task automatic test_random();
    int r;
    bit en, clr;
    logic [N-1:0] ring;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 99);
      if (r < 75)      ring = onehot((m_prev_pos >= 0) ? (m_prev_pos + 1) % N : $urandom_range(0, N - 1));
      else if (r < 88) ring = onehot($urandom_range(0, N - 1));
      else             ring = N'($urandom);
      drive(en, ring, clr);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++; $display("FAIL random_cycle_%0d: en=%b ring=%b clr=%b got %b want %b",
                           c, en, ring, clr, observed(), expected());
      end
    end
  endtask

  initial begin
    reset = 0; en_i = 0; clr_i = 0; ring_i = '0;
    model_reset();
    test_reset();
    test_lock_wrap();
    test_seq_error();
    test_nonhot_error();
    test_saturate_clear();
    test_hold();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
